// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default sizes and the
// bus-owner encoding used by the round-robin burst arbiter.
package ram_arb_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_MAX_BURST = 4;

    // Port that currently holds the bus for burst counting.
    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesting ports, the arbiter and the RAM.
// The arbiter sits on the slave modport; the client/RAM side uses master.
interface ram_arbiter_if #(
    parameter int WIDTH = ram_arb_pkg::DEFAULT_WIDTH
) ();

    // Port 0
    logic             P0_REQ;
    logic             P0_WE;
    logic [WIDTH-1:0] P0_ADDRESS;
    logic [WIDTH-1:0] P0_WD;
    logic             P0_GNT;
    logic [WIDTH-1:0] P0_RD;
    logic             P0_RVALID;

    // Port 1
    logic             P1_REQ;
    logic             P1_WE;
    logic [WIDTH-1:0] P1_ADDRESS;
    logic [WIDTH-1:0] P1_WD;
    logic             P1_GNT;
    logic [WIDTH-1:0] P1_RD;
    logic             P1_RVALID;

    // RAM side (asynchronous read)
    logic             RAM_WE;
    logic [WIDTH-1:0] RAM_ADDRESS;
    logic [WIDTH-1:0] RAM_WD;
    logic [WIDTH-1:0] RAM_RD;

    modport master (
        output P0_REQ, P0_WE, P0_ADDRESS, P0_WD,
        input  P0_GNT, P0_RD, P0_RVALID,
        output P1_REQ, P1_WE, P1_ADDRESS, P1_WD,
        input  P1_GNT, P1_RD, P1_RVALID,
        input  RAM_WE, RAM_ADDRESS, RAM_WD,
        output RAM_RD
    );

    modport slave (
        input  P0_REQ, P0_WE, P0_ADDRESS, P0_WD,
        output P0_GNT, P0_RD, P0_RVALID,
        input  P1_REQ, P1_WE, P1_ADDRESS, P1_WD,
        output P1_GNT, P1_RD, P1_RVALID,
        output RAM_WE, RAM_ADDRESS, RAM_WD,
        input  RAM_RD
    );

endinterface

// File: rtl/ram_arb_rr.sv
// Burst-limited round-robin arbiter: tracks the bus owner and how many
// consecutive grants it has taken, and produces the combinational grants.
module ram_arb_rr
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam int CW = $clog2(MAX_BURST + 1);

    owner_t        owner;
    logic [CW-1:0] cnt;
    // Cleared by reset: the owner left by reset has no burst in progress,
    // so the first contention goes to P0 instead of extending P1.
    logic          burst_live;
    logic          owner_keeps;

    // Grant decision: a lone requester always wins; on contention the owner
    // keeps the bus until its burst is exhausted.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        owner_keeps = burst_live && (cnt < CW'(MAX_BURST));
        if (RST_N) begin
            if (req0 && req1) begin
                if (owner_keeps) begin
                    gnt0 = (owner == OWN0);
                    gnt1 = (owner == OWN1);
                end else begin
                    gnt0 = (owner == OWN1);
                    gnt1 = (owner == OWN0);
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Owner/burst-count update on every accepted transfer.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (!RST_N) begin
            owner      <= OWN1;
            cnt        <= CW'(1);
            burst_live <= 1'b0;
        end else if (gnt0 || gnt1) begin
            burst_live <= 1'b1;
            if ((gnt0 && owner == OWN0) || (gnt1 && owner == OWN1)) begin
                if (cnt < CW'(MAX_BURST)) begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                owner <= gnt0 ? OWN0 : OWN1;
                cnt   <= CW'(1);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single asynchronous-read RAM.
// Accept (k) -> registered RAM access (k+1) -> registered read return (k+2).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic          CLK,
    input  logic          RST_N,
    ram_arbiter_if.slave  bus
);

    logic             gnt0;
    logic             gnt1;
    logic             acc;
    logic             acc_we;
    logic [WIDTH-1:0] acc_addr;
    logic [WIDTH-1:0] acc_wd;

    // Access stage registers (drive the RAM).
    logic             we_q;
    logic             rd_q;
    logic             port_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wd_q;

    // Return stage registers.
    logic             rvalid0_q;
    logic             rvalid1_q;
    logic [WIDTH-1:0] rd0_q;
    logic [WIDTH-1:0] rd1_q;

    ram_arb_rr #(
        .MAX_BURST (MAX_BURST)
    ) u_rr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req0  (bus.P0_REQ),
        .req1  (bus.P1_REQ),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign bus.P0_GNT = gnt0;
    assign bus.P1_GNT = gnt1;

    // Select the command of whichever port was granted this cycle.
    always_comb begin
        acc      = gnt0 || gnt1;
        acc_we   = bus.P0_WE;
        acc_addr = bus.P0_ADDRESS;
        acc_wd   = bus.P0_WD;
        if (gnt1) begin
            acc_we   = bus.P1_WE;
            acc_addr = bus.P1_ADDRESS;
            acc_wd   = bus.P1_WD;
        end
    end

    // Access stage: register the accepted command; address/data hold when idle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            we_q   <= 1'b0;
            rd_q   <= 1'b0;
            port_q <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
        end else begin
            we_q   <= acc && acc_we;
            rd_q   <= acc && !acc_we;
            port_q <= gnt1;
            if (acc) begin
                addr_q <= acc_addr;
            end
            if (acc && acc_we) begin
                wd_q <= acc_wd;
            end
        end
    end

    // A write whose access cycle coincides with reset must not reach the RAM.
    assign bus.RAM_WE      = we_q && RST_N;
    assign bus.RAM_ADDRESS = addr_q;
    assign bus.RAM_WD      = wd_q;

    // Return stage: capture RAM read data for the requesting port and pulse RVALID.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            rvalid0_q <= rd_q && !port_q;
            rvalid1_q <= rd_q && port_q;
            if (rd_q && !port_q) begin
                rd0_q <= bus.RAM_RD;
            end
            if (rd_q && port_q) begin
                rd1_q <= bus.RAM_RD;
            end
        end
    end

    assign bus.P0_RVALID = rvalid0_q;
    assign bus.P1_RVALID = rvalid1_q;
    assign bus.P0_RD     = rd0_q;
    assign bus.P1_RD     = rd1_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width in bits.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to one port while the other port waits.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports P0_REQ / P1_REQ  input  1  access request from port n.
REQ-006 SHALL have ports P0_WE / P1_WE  input  1  write (1) or read (0) request, qualified by REQ.
REQ-007 SHALL have ports P0_ADDRESS / P1_ADDRESS  input  WIDTH  word address.
REQ-008 SHALL have ports P0_WD / P1_WD  input  WIDTH  write data.
REQ-009 SHALL have ports P0_GNT / P1_GNT  output  1  request accepted this cycle (combinational).
REQ-010 SHALL have ports P0_RD / P1_RD  output  WIDTH  registered read data.
REQ-011 SHALL have ports P0_RVALID / P1_RVALID  output  1  one-cycle pulse, RD valid.
REQ-012 SHALL have port RAM_WE  output  1  write enable to the RAM.
REQ-013 SHALL have port RAM_ADDRESS  output  WIDTH  RAM address.
REQ-014 SHALL have port RAM_WD  output  WIDTH  RAM write data.
REQ-015 SHALL have port RAM_RD  input  WIDTH  asynchronous RAM read data.

Function
REQ-016 Transfer occurs on a cycle where Pn_REQ and Pn_GNT are both high; at most one GNT is high per cycle.
REQ-017 GNT is high only while RST_N is high; a port with REQ low never receives GNT.
REQ-018 Pipeline: accept cycle k -> RAM access cycle k+1 (RAM_* from registers) -> Pn_RVALID and Pn_RD in cycle k+2 for reads.
REQ-019 Writes produce no RVALID; RAM_WE is high only in the access cycle of an accepted write.
REQ-020 Throughput: one accepted transfer per cycle, back-to-back, no bubbles.
REQ-021 Arbitration states: OWN0 and OWN1, each with burst counter CNT (1..MAX_BURST).
REQ-022 If only one port requests, it is granted; if it equals the owner, CNT increments saturating at MAX_BURST, else owner switches and CNT=1.
REQ-023 If both request: owner is granted while CNT < MAX_BURST; at CNT == MAX_BURST the other port is granted, owner switches, CNT=1.
REQ-024 No request: owner and CNT hold.
REQ-025 Idle access cycles drive RAM_WE=0; RAM_ADDRESS and RAM_WD hold their last values.
REQ-026 RAM_RD is captured into Pn_RD at the end of the access cycle; Pn_RD holds until the next read completion for that port.
REQ-027 Read-after-write to the same address, accepted in consecutive cycles, returns the new data.

Reset
REQ-028 While RST_N is low at a rising edge: owner=OWN1 (P0 wins first contention), CNT=1, pipeline valid bits cleared, RAM_WE=0, RAM_ADDRESS=0, RAM_WD=0, P0_RD=P1_RD=0, RVALID=0.
REQ-029 Reset mid-operation discards in-flight transfers: no RAM write and no RVALID occur for them after reset.

Structure
REQ-030 Package ram_arb_pkg SHALL hold the default WIDTH, MAX_BURST, and the owner enum (OWN0, OWN1).
REQ-031 Sub-module ram_arb_rr SHALL hold owner/CNT state and compute GNT; ram_arbiter holds the pipeline registers and RAM drive.

Verification
REQ-032 P0 writes 0xDEADBEEF to address 5 (cycle 0), P1 reads address 5 (cycle 1) -> RAM_WE=1 in cycle 1, P1_RVALID and P1_RD=0xDEADBEEF in cycle 3.
REQ-033 Both ports hold REQ for 10 cycles with MAX_BURST=4 -> grant order P0 x4, P1 x4, P0 x2.
REQ-034 P1 alone requests reads of addresses 0..7 -> 8 consecutive GNTs; RVALID pulses in cycles 2..9 with matching data.
REQ-035 Accept a P0 read in cycle 0, assert RST_N=0 in cycle 1 -> no P0_RVALID; all outputs at reset values in cycle 2.
REQ-036 Both ports request in the first cycle after reset -> P0_GNT=1 and P1_GNT=0.
